// File: rtl/dut_engine.sv
// dut_engine: stimulus/response sequencer between three FIFOs and an
// external DUT.
//
// A stimulus word {data, cycles, mode} is popped from the stimulus FIFO and
// its data is driven on mosi_data. A cycle counter then runs until either
// the cycle budget is reached or, in trigger modes, miso_data satisfies the
// trigger condition. The result {miso_data, counter, timeout, match} is
// pushed into the result FIFO. Config words {cmd, payload} are popped only
// while idle with no stimulus pending. They load the mosi clock-mux mask
// (0x01), the trigger mask (0x02) or the trigger value (0x03).
//
// Build option: define DUT_ENGINE_EDGE_TRIG_EN to make mode 2'b10 an edge
// trigger, where a change of masked miso_data ends the run. Without it,
// mode 2'b10 is a plain count mode and no previous-sample register exists.
//
// Handshake: every FIFO port is a show-ahead FIFO. A *_rdreq pulse consumes
// the word that is visible in the same cycle. rfifo_wrreq is asserted only
// while rfifo_wrfull is low, so each assertion is exactly one push.
//
// Ports:
//   clock, reset_n   single clock, asynchronous active-low reset
//   sfifo_*          stimulus FIFO read side
//   dififo_*         config FIFO read side
//   rfifo_*          result FIFO write side
//   mosi_data        data driven to the DUT, with optional gated-clock bits
//   miso_data        data sampled from the DUT
//   busy             high whenever the engine is not idle
//   state_dbg        current FSM state (0 idle, 1 run, 2 write)
module dut_engine #(
  parameter int STF_WIDTH   = 24,
  parameter int RTF_WIDTH   = 24,
  parameter int CYCLE_RANGE = 8,
  parameter int CMD_WIDTH   = 8
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic [STF_WIDTH+CYCLE_RANGE+1:0]   sfifo_data,
  output logic                               sfifo_rdreq,
  input  logic                               sfifo_rdempty,
  input  logic [CMD_WIDTH+STF_WIDTH-1:0]     dififo_data,
  output logic                               dififo_rdreq,
  input  logic                               dififo_rdempty,
  output logic [RTF_WIDTH+CYCLE_RANGE+1:0]   rfifo_data,
  output logic                               rfifo_wrreq,
  input  logic                               rfifo_wrfull,
  output logic [STF_WIDTH-1:0]               mosi_data,
  input  logic [RTF_WIDTH-1:0]               miso_data,
  output logic                               busy,
  output logic [1:0]                         state_dbg
);

  localparam int DIF_WIDTH = CMD_WIDTH + STF_WIDTH;
  localparam int SF_WIDTH  = STF_WIDTH + CYCLE_RANGE + 2;

  localparam logic [CMD_WIDTH-1:0] CMD_MUX   = CMD_WIDTH'(1);
  localparam logic [CMD_WIDTH-1:0] CMD_MASK  = CMD_WIDTH'(2);
  localparam logic [CMD_WIDTH-1:0] CMD_VALUE = CMD_WIDTH'(3);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [STF_WIDTH-1:0]   stim_data;
  logic [CYCLE_RANGE-1:0] stim_cycles;
  logic [1:0]             stim_mode;
  logic [CYCLE_RANGE-1:0] counter;
  logic [STF_WIDTH-1:0]   mux_config;
  logic [RTF_WIDTH-1:0]   trig_mask;
  logic [RTF_WIDTH-1:0]   trig_value;
  logic                   stall_n;
  logic                   clock_gated;

  logic                   stim_pop;
  logic                   cfg_pop;
  logic [CMD_WIDTH-1:0]   cfg_cmd;
  logic [STF_WIDTH-1:0]   cfg_payload;
  logic [RTF_WIDTH-1:0]   miso_masked;
  logic                   level_mode;
  logic                   edge_mode;
  logic                   edge_hit;
  logic                   run_hit;
  logic                   run_expired;
  logic                   run_done;
  logic                   run_timeout;

  assign cfg_cmd     = dififo_data[DIF_WIDTH-1 -: CMD_WIDTH];
  assign cfg_payload = dififo_data[STF_WIDTH-1:0];

  // Stimulus wins over config when both are pending in the same idle cycle.
  assign stim_pop = (state == S_IDLE) && !sfifo_rdempty;
  assign cfg_pop  = (state == S_IDLE) && sfifo_rdempty && !dififo_rdempty;

  assign sfifo_rdreq  = stim_pop;
  assign dififo_rdreq = cfg_pop;
  assign rfifo_wrreq  = (state == S_WRITE) && !rfifo_wrfull;
  assign busy         = (state != S_IDLE);
  assign state_dbg    = state;

  // The gated clock stops while the result FIFO is full, so a clocked DUT
  // cannot run ahead of a result that has not been stored yet.
  assign clock_gated = clock & stall_n;
  assign mosi_data   = (mux_config & {STF_WIDTH{clock_gated}}) |
                       (~mux_config & stim_data);

  assign miso_masked = miso_data & trig_mask;
  assign level_mode  = (stim_mode == 2'b01);

`ifdef DUT_ENGINE_EDGE_TRIG_EN
  logic [RTF_WIDTH-1:0] prev_masked;

  assign edge_mode = (stim_mode == 2'b10);
  // The first run cycle has no previous sample, so it can never match.
  assign edge_hit  = (counter != '0) && (miso_masked != prev_masked);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_masked <= '0;
    end else if (state == S_RUN) begin
      prev_masked <= miso_masked;
    end
  end
`else
  assign edge_mode = 1'b0;
  assign edge_hit  = 1'b0;
`endif

  assign run_hit     = (level_mode && (miso_masked == (trig_value & trig_mask))) ||
                       (edge_mode && edge_hit);
  assign run_expired = (counter == stim_cycles);
  assign run_done    = run_hit || run_expired;
  // A match reported in the same cycle as expiry is not a timeout.
  assign run_timeout = (level_mode || edge_mode) && !run_hit;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (stim_pop) state_nxt = S_RUN;
      S_RUN:   if (run_done) state_nxt = S_WRITE;
      S_WRITE: if (!rfifo_wrfull) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_n <= 1'b1;
    end else begin
      stall_n <= !rfifo_wrfull;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stim_data   <= '0;
      stim_cycles <= '0;
      stim_mode   <= '0;
      counter     <= '0;
      mux_config  <= '0;
      trig_mask   <= '0;
      trig_value  <= '0;
      rfifo_data  <= '0;
    end else begin
      if (stim_pop) begin
        stim_data   <= sfifo_data[SF_WIDTH-1 -: STF_WIDTH];
        stim_cycles <= sfifo_data[CYCLE_RANGE+1:2];
        stim_mode   <= sfifo_data[1:0];
        counter     <= '0;
      end
      if (cfg_pop) begin
        case (cfg_cmd)
          CMD_MUX:   mux_config <= cfg_payload;
          CMD_MASK:  trig_mask  <= cfg_payload[RTF_WIDTH-1:0];
          CMD_VALUE: trig_value <= cfg_payload[RTF_WIDTH-1:0];
          default:   ;
        endcase
      end
      // The counter stops at the value reported. Because the run ends at
      // counter == cycles, it never needs to wrap.
      if (state == S_RUN) begin
        if (run_done) begin
          rfifo_data <= {miso_data, counter, run_timeout, run_hit};
        end else begin
          counter <= counter + CYCLE_RANGE'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dut_engine.sv
// Directed testbench for dut_engine with default parameters.
// Inputs change 2 time units after the rising edge. Outputs are checked
// 1 unit later. Pushes are recorded on the falling edge.
module tb_dut_engine;

  logic        clock;
  logic        reset_n;
  logic [33:0] sfifo_data;
  logic        sfifo_rdreq;
  logic        sfifo_rdempty;
  logic [31:0] dififo_data;
  logic        dififo_rdreq;
  logic        dififo_rdempty;
  logic [33:0] rfifo_data;
  logic        rfifo_wrreq;
  logic        rfifo_wrfull;
  logic [23:0] mosi_data;
  logic [23:0] miso_data;
  logic        busy;
  logic [1:0]  state_dbg;

  int n_cmp;
  int n_fail;
  int cyc;
  int push_cnt;
  int push_cyc;
  int pop_cyc;
  logic [33:0] push_data;

  dut_engine dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .sfifo_data     (sfifo_data),
    .sfifo_rdreq    (sfifo_rdreq),
    .sfifo_rdempty  (sfifo_rdempty),
    .dififo_data    (dififo_data),
    .dififo_rdreq   (dififo_rdreq),
    .dififo_rdempty (dififo_rdempty),
    .rfifo_data     (rfifo_data),
    .rfifo_wrreq    (rfifo_wrreq),
    .rfifo_wrfull   (rfifo_wrfull),
    .mosi_data      (mosi_data),
    .miso_data      (miso_data),
    .busy           (busy),
    .state_dbg      (state_dbg)
  );

  // Clock and cycle index.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  // Result FIFO monitor.
  initial push_cnt = 0;
  always @(negedge clock) begin
    if (rfifo_wrreq === 1'b1) begin
      push_cnt  = push_cnt + 1;
      push_cyc  = cyc;
      push_data = rfifo_data;
    end
  end

  // Driver tasks.
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic push_stim(input logic [23:0] d, input logic [7:0] c, input logic [1:0] m);
    sfifo_data    = {d, c, m};
    sfifo_rdempty = 1'b0;
    #1;
    n_cmp++;
    if (sfifo_rdreq !== 1'b1) begin
      n_fail++;
      $display("FAIL stim_pop: rdreq got %b expected 1", sfifo_rdreq);
    end
    pop_cyc = cyc;
    step();
    sfifo_rdempty = 1'b1;
  endtask

  task automatic cfg_write(input logic [7:0] cmd, input logic [23:0] payload);
    dififo_data    = {cmd, payload};
    dififo_rdempty = 1'b0;
    #1;
    n_cmp++;
    if (dififo_rdreq !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_pop: rdreq got %b expected 1", dififo_rdreq);
    end
    step();
    dififo_rdempty = 1'b1;
  endtask

  task automatic wait_push(input int budget);
    int start;
    start = push_cnt;
    for (int i = 0; i < budget && push_cnt == start; i++) step();
    n_cmp++;
    if (push_cnt == start) begin
      n_fail++;
      $display("FAIL wait_push: got no push expected one within %0d cycles", budget);
    end
  endtask

  // Scenarios.
  task automatic test_reset();
    reset_n = 1'b0;
    #23;
    n_cmp++;
    if (busy !== 1'b0 || state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy %b state %0d expected 0/0", busy, state_dbg);
    end
    n_cmp++;
    if (rfifo_wrreq !== 1'b0 || rfifo_data !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_rfifo: wrreq %b data %h expected 0/0", rfifo_wrreq, rfifo_data);
    end
    n_cmp++;
    if (mosi_data !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_mosi: got %h expected 000000", mosi_data);
    end
    n_cmp++;
    if (sfifo_rdreq !== 1'b0 || dififo_rdreq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rdreq: got %b%b expected 00", sfifo_rdreq, dififo_rdreq);
    end
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_count();
    miso_data = 24'h000111;
    push_stim(24'hA5A5A5, 8'd5, 2'b00);
    #1;
    n_cmp++;
    if (mosi_data !== 24'hA5A5A5 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL count_mosi: mosi %h busy %b expected a5a5a5/1", mosi_data, busy);
    end
    wait_push(20);
    n_cmp++;
    if (push_cyc - pop_cyc !== 7) begin
      n_fail++;
      $display("FAIL count_latency: got %0d expected 7", push_cyc - pop_cyc);
    end
    n_cmp++;
    if (push_data !== {24'h000111, 8'd5, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL count_result: got %h expected %h", push_data, {24'h000111, 8'd5, 1'b0, 1'b0});
    end
    step();
  endtask

  task automatic test_trigger_hit();
    cfg_write(8'h02, 24'h0000FF);
    cfg_write(8'h03, 24'h000042);
    miso_data = 24'h123400;
    push_stim(24'h000000, 8'd20, 2'b01);
    step();
    step();
    step();
    miso_data = 24'h123442;
    wait_push(20);
    n_cmp++;
    if (push_data !== {24'h123442, 8'd3, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL trig_result: got %h expected %h", push_data, {24'h123442, 8'd3, 1'b0, 1'b1});
    end
    n_cmp++;
    if (push_cyc - pop_cyc !== 5) begin
      n_fail++;
      $display("FAIL trig_latency: got %0d expected 5", push_cyc - pop_cyc);
    end
    step();
  endtask

  task automatic test_timeout();
    miso_data = 24'h000000;
    push_stim(24'h000000, 8'd10, 2'b01);
    wait_push(30);
    n_cmp++;
    if (push_data !== {24'h000000, 8'd10, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL timeout_10: got %h expected %h", push_data, {24'h000000, 8'd10, 1'b1, 1'b0});
    end
    step();
    push_stim(24'h000000, 8'd0, 2'b01);
    wait_push(10);
    n_cmp++;
    if (push_data !== {24'h000000, 8'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL timeout_0: got %h expected %h", push_data, {24'h000000, 8'd0, 1'b1, 1'b0});
    end
    n_cmp++;
    if (push_cyc - pop_cyc !== 2) begin
      n_fail++;
      $display("FAIL timeout_0_latency: got %0d expected 2", push_cyc - pop_cyc);
    end
    step();
  endtask

  task automatic test_collision();
    miso_data      = 24'h000777;
    dififo_data    = {8'h01, 24'h000001};
    dififo_rdempty = 1'b0;
    sfifo_data     = {24'h000000, 8'd1, 2'b00};
    sfifo_rdempty  = 1'b0;
    #1;
    n_cmp++;
    if (sfifo_rdreq !== 1'b1 || dififo_rdreq !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_priority: s/d rdreq got %b%b expected 10", sfifo_rdreq, dififo_rdreq);
    end
    pop_cyc = cyc;
    step();
    sfifo_rdempty = 1'b1;
    #1;
    n_cmp++;
    if (dififo_rdreq !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_busy_cfg: rdreq got %b expected 0", dififo_rdreq);
    end
    wait_push(10);
    #1;
    n_cmp++;
    if (dififo_rdreq !== 1'b1) begin
      n_fail++;
      $display("FAIL collide_cfg_after: rdreq got %b expected 1", dififo_rdreq);
    end
    step();
    dififo_rdempty = 1'b1;
    #1;
    n_cmp++;
    if (mosi_data !== 24'h000001) begin
      n_fail++;
      $display("FAIL mux_high: got %h expected 000001", mosi_data);
    end
    #3;
    n_cmp++;
    if (mosi_data !== 24'h000000) begin
      n_fail++;
      $display("FAIL mux_low: got %h expected 000000", mosi_data);
    end
    step();
  endtask

  task automatic test_backpressure();
    int start;
    miso_data    = 24'h00ABCD;
    rfifo_wrfull = 1'b1;
    push_stim(24'hFFFFFF, 8'd2, 2'b00);
    for (int i = 0; i < 10 && state_dbg !== 2'd2; i++) step();
    start = push_cnt;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_cmp++;
      if (state_dbg !== 2'd2 || rfifo_wrreq !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold: state %0d wrreq %b expected 2/0", state_dbg, rfifo_wrreq);
      end
      n_cmp++;
      if (rfifo_data !== {24'h00ABCD, 8'd2, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_data: got %h expected %h", rfifo_data, {24'h00ABCD, 8'd2, 1'b0, 1'b0});
      end
      n_cmp++;
      if (mosi_data !== 24'hFFFFFE) begin
        n_fail++;
        $display("FAIL bp_gated: got %h expected fffffe", mosi_data);
      end
      step();
    end
    rfifo_wrfull = 1'b0;
    wait_push(5);
    step();
    step();
    n_cmp++;
    if (push_cnt - start !== 1 || push_data !== {24'h00ABCD, 8'd2, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL bp_release: pushes %0d data %h expected 1/%h", push_cnt - start, push_data,
               {24'h00ABCD, 8'd2, 1'b0, 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    miso_data = 24'h00BEEF;
    push_stim(24'h111111, 8'd1, 2'b00);
    sfifo_data    = {24'h222222, 8'd1, 2'b00};
    sfifo_rdempty = 1'b0;
    #1;
    n_cmp++;
    if (sfifo_rdreq !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_busy_pop: got %b expected 0", sfifo_rdreq);
    end
    wait_push(10);
    #1;
    n_cmp++;
    if (sfifo_rdreq !== 1'b1 || state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL b2b_accept: rdreq %b state %0d expected 1/0", sfifo_rdreq, state_dbg);
    end
    pop_cyc = cyc;
    step();
    sfifo_rdempty = 1'b1;
    #1;
    n_cmp++;
    if (mosi_data[23:1] !== 23'h111111) begin
      n_fail++;
      $display("FAIL b2b_mosi: got %h expected 222222 upper bits", mosi_data);
    end
    wait_push(10);
    n_cmp++;
    if (push_cyc - pop_cyc !== 3 || push_data !== {24'h00BEEF, 8'd1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_second: latency %0d data %h expected 3/%h", push_cyc - pop_cyc,
               push_data, {24'h00BEEF, 8'd1, 1'b0, 1'b0});
    end
    step();
  endtask

  task automatic test_reset_mid_run();
    int start;
    start = push_cnt;
    miso_data = 24'h000000;
    push_stim(24'h3C3C3C, 8'd10, 2'b00);
    step();
    step();
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || state_dbg !== 2'd0 || rfifo_wrreq !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_state: busy %b state %0d wrreq %b expected 0/0/0", busy, state_dbg, rfifo_wrreq);
    end
    n_cmp++;
    if (mosi_data !== 24'h0 || rfifo_data !== 34'h0) begin
      n_fail++;
      $display("FAIL midrst_data: mosi %h rfifo %h expected 0/0", mosi_data, rfifo_data);
    end
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 15; i++) step();
    n_cmp++;
    if (push_cnt !== start) begin
      n_fail++;
      $display("FAIL midrst_no_push: got %0d pushes expected 0", push_cnt - start);
    end
    // Cleared trigger mask means the level trigger matches immediately;
    // cleared mux mask means mosi shows plain stimulus data.
    miso_data = 24'hABCDEF;
    push_stim(24'h777777, 8'd5, 2'b01);
    #1;
    n_cmp++;
    if (mosi_data !== 24'h777777) begin
      n_fail++;
      $display("FAIL midrst_mux_cleared: got %h expected 777777", mosi_data);
    end
    wait_push(10);
    n_cmp++;
    if (push_data !== {24'hABCDEF, 8'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL midrst_trig_cleared: got %h expected %h", push_data, {24'hABCDEF, 8'd0, 1'b0, 1'b1});
    end
    step();
  endtask

  task automatic test_mode10();
`ifdef DUT_ENGINE_EDGE_TRIG_EN
    cfg_write(8'h02, 24'h0000FF);
    miso_data = 24'h000010;
    push_stim(24'h000000, 8'd20, 2'b10);
    step();
    step();
    step();
    step();
    miso_data = 24'h000020;
    wait_push(30);
    n_cmp++;
    if (push_data !== {24'h000020, 8'd4, 1'b0, 1'b1} || push_cyc - pop_cyc !== 6) begin
      n_fail++;
      $display("FAIL edge_trig: data %h latency %0d expected %h/6", push_data, push_cyc - pop_cyc,
               {24'h000020, 8'd4, 1'b0, 1'b1});
    end
`else
    miso_data = 24'h000055;
    push_stim(24'h000000, 8'd3, 2'b10);
    wait_push(20);
    n_cmp++;
    if (push_data !== {24'h000055, 8'd3, 1'b0, 1'b0} || push_cyc - pop_cyc !== 5) begin
      n_fail++;
      $display("FAIL mode10_count: data %h latency %0d expected %h/5", push_data, push_cyc - pop_cyc,
               {24'h000055, 8'd3, 1'b0, 1'b0});
    end
`endif
    step();
  endtask

  initial begin
    n_cmp          = 0;
    n_fail         = 0;
    reset_n        = 1'b0;
    sfifo_data     = '0;
    sfifo_rdempty  = 1'b1;
    dififo_data    = '0;
    dififo_rdempty = 1'b1;
    rfifo_wrfull   = 1'b0;
    miso_data      = '0;
    test_reset();
    test_count();
    test_trigger_hit();
    test_timeout();
    test_collision();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_mode10();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
